// File: rtl/counter_pkg.sv
// ---------------------------------------------------------------------------
// counter_pkg
//   Shared definitions for the parametrised up/down counter.
//   - counter_mode_t : 2-bit boundary-mode selector
//   - MODE_*         : encodings of the boundary modes
//   - is_wrap_mode() : helper that folds the reserved encoding onto WRAP
// ---------------------------------------------------------------------------
package counter_pkg;

    typedef logic [1:0] counter_mode_t;

    localparam counter_mode_t MODE_WRAP    = 2'b00;
    localparam counter_mode_t MODE_SAT     = 2'b01;
    localparam counter_mode_t MODE_ONESHOT = 2'b10;
    // The fourth encoding is reserved and treated exactly like WRAP.
    localparam counter_mode_t MODE_RSVD    = 2'b11;

    // True for every encoding that wraps at the bound (WRAP and reserved).
    function automatic logic is_wrap_mode(input counter_mode_t mode);
        return (mode == MODE_WRAP) || (mode == MODE_RSVD);
    endfunction

endpackage

// File: rtl/dff_bank.sv
// ---------------------------------------------------------------------------
// dff_bank
//   WIDTH-bit register with asynchronous active-low reset. Used for the count
//   register and, as 1-bit instances, for the tc and done flags.
// Parameters
//   WIDTH    register width in bits
//   RST_VAL  value loaded while rst is low
// Ports
//   clk   in   1      rising-edge clock
//   rst   in   1      asynchronous, active-low reset
//   d     in   WIDTH  next-state value
//   q     out  WIDTH  registered value
// ---------------------------------------------------------------------------
module dff_bank #(
    parameter int                 WIDTH   = 1,
    parameter logic [WIDTH-1:0]   RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its input before any of them update on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= RST_VAL;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/updown_counter_param.sv
// ---------------------------------------------------------------------------
// updown_counter_param
//   Parametrised synchronous up/down counter with parallel load, count enable,
//   selectable boundary behaviour (wrap / saturate / one-shot) and a
//   registered terminal-count pulse. Typically used as a programmable divider
//   or timer.
// Parameters
//   WIDTH    counter width in bits (>= 2)
//   MAX_VAL  upper count bound, range is 0..MAX_VAL (< 2**WIDTH)
//   RST_VAL  count value while reset is asserted (<= MAX_VAL)
// Ports
//   clk       in   1      rising-edge clock
//   rst       in   1      asynchronous, active-low reset
//   en        in   1      count enable, one step per edge
//   up        in   1      1 = increment, 0 = decrement
//   load      in   1      synchronous parallel load (highest priority)
//   load_val  in   WIDTH  value to load, clamped to MAX_VAL
//   mode      in   2      boundary mode (counter_mode_t)
//   count     out  WIDTH  current count, registered
//   tc        out  1      one-cycle terminal-count pulse, registered
//   sat       out  1      at bound in SAT mode, combinational
//   done      out  1      one-shot halted flag, registered
// ---------------------------------------------------------------------------
module updown_counter_param
    import counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MAX_VAL = (1 << WIDTH) - 1,
    parameter int RST_VAL = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                up,
    input  logic                load,
    input  logic [WIDTH-1:0]    load_val,
    input  counter_mode_t       mode,
    output logic [WIDTH-1:0]    count,
    output logic                tc,
    output logic                sat,
    output logic                done
);

    localparam logic [WIDTH-1:0] MAX_V = MAX_VAL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] RST_V = RST_VAL[WIDTH-1:0];

    logic [WIDTH-1:0] count_d;
    logic             tc_d;
    logic             done_d;
    logic [WIDTH-1:0] bound;
    logic             at_bound;

    // The bound being approached depends on the current direction, so a
    // direction change re-targets the compare on the very next edge.
    assign bound    = up ? MAX_V : '0;
    assign at_bound = (count == bound);
    assign sat      = (mode == MODE_SAT) && at_bound;

    // Next-state logic. Priority: load > step > hold.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        count_d = count;
        tc_d    = 1'b0;
        done_d  = done;

        if (load) begin
            // Clamp so values above MAX_VAL can never be held.
            count_d = (load_val > MAX_V) ? MAX_V : load_val;
            done_d  = 1'b0;
        end else if (en && !done) begin
            if (!at_bound) begin
                // Plain WIDTH-bit arithmetic; the modulus comes only from the
                // bound compare above.
                count_d = up ? count + WIDTH'(1) : count - WIDTH'(1);
            end else if (mode == MODE_SAT) begin
                count_d = count;
            end else if (mode == MODE_ONESHOT) begin
                // Halt at the bound; done blocks further steps, so this tc
                // fires only once until the next load or reset.
                done_d = 1'b1;
                tc_d   = 1'b1;
            end else if (is_wrap_mode(mode)) begin
                count_d = up ? '0 : MAX_V;
                tc_d    = 1'b1;
            end
        end
    end

    dff_bank #(
        .WIDTH   (WIDTH),
        .RST_VAL (RST_V)
    ) u_count_reg (
        .clk (clk),
        .rst (rst),
        .d   (count_d),
        .q   (count)
    );

    dff_bank #(
        .WIDTH   (1),
        .RST_VAL (1'b0)
    ) u_tc_reg (
        .clk (clk),
        .rst (rst),
        .d   (tc_d),
        .q   (tc)
    );

    dff_bank #(
        .WIDTH   (1),
        .RST_VAL (1'b0)
    ) u_done_reg (
        .clk (clk),
        .rst (rst),
        .d   (done_d),
        .q   (done)
    );

endmodule

// File: tb/tb_updown_counter_param.sv
// ---------------------------------------------------------------------------
// tb_updown_counter_param
//   Two counters (MAX_VAL=15 and MAX_VAL=9, WIDTH=4) share one stimulus
//   stream. A driver applies inputs on the falling edge, checks sat, advances
//   a behavioural model and queues the expected post-edge state; a monitor
//   pops that queue after each rising edge and compares count/tc/done.
// ---------------------------------------------------------------------------
module tb_updown_counter_param;
    import counter_pkg::*;

    localparam int WIDTH = 4;
    localparam int NDUT  = 2;
    localparam int MAXV [NDUT] = '{15, 9};

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             en = 1'b0;
    logic             up = 1'b0;
    logic             load = 1'b0;
    logic [WIDTH-1:0] load_val = '0;
    counter_mode_t    mode = MODE_WRAP;

    logic [WIDTH-1:0] count_a, count_b;
    logic             tc_a, tc_b, sat_a, sat_b, done_a, done_b;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int c [NDUT];
        bit t [NDUT];
        bit d [NDUT];
    } exp_t;

    exp_t exp_q [$];

    // Model state: plain integers.
    int m_count [NDUT];
    bit m_done  [NDUT];

    always #5 clk = ~clk;

    updown_counter_param #(.WIDTH(WIDTH), .MAX_VAL(15), .RST_VAL(0)) dut_a (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .mode(mode), .count(count_a), .tc(tc_a), .sat(sat_a), .done(done_a)
    );

    updown_counter_param #(.WIDTH(WIDTH), .MAX_VAL(9), .RST_VAL(0)) dut_b (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .mode(mode), .count(count_b), .tc(tc_b), .sat(sat_b), .done(done_b)
    );

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, req, $time);
        end
    endtask

    function automatic int dut_count(input int k);
        return (k == 0) ? int'(count_a) : int'(count_b);
    endfunction
    function automatic int dut_tc(input int k);
        return (k == 0) ? int'(tc_a) : int'(tc_b);
    endfunction
    function automatic int dut_done(input int k);
        return (k == 0) ? int'(done_a) : int'(done_b);
    endfunction
    function automatic int dut_sat(input int k);
        return (k == 0) ? int'(sat_a) : int'(sat_b);
    endfunction

    // Reference behaviour, stated directly from the counter's rules:
    // the range is 0..mx, wrap is modular arithmetic over mx+1 values.
    task automatic model_step(input int k, input bit ld, input int lv, input bit e,
                              input bit u, input int md, output bit tc_out);
        int mx;
        bit at_b;
        mx     = MAXV[k];
        tc_out = 1'b0;
        if (ld) begin
            m_count[k] = (lv > mx) ? mx : lv;
            m_done[k]  = 1'b0;
        end else if (e && !m_done[k]) begin
            at_b = u ? (m_count[k] == mx) : (m_count[k] == 0);
            if (!at_b) begin
                m_count[k] = u ? m_count[k] + 1 : m_count[k] - 1;
            end else if (md == 1) begin
                tc_out = 1'b0;
            end else if (md == 2) begin
                m_done[k] = 1'b1;
                tc_out    = 1'b1;
            end else begin
                m_count[k] = u ? (m_count[k] + 1) % (mx + 1) : (m_count[k] + mx) % (mx + 1);
                tc_out     = 1'b1;
            end
        end
    endtask

    // One clock of stimulus: drive, check sat, advance model, queue expectation.
    task automatic cycle(input bit ld, input int lv, input bit e, input bit u, input int md);
        exp_t x;
        bit   t;
        @(negedge clk);
        load     = ld;
        load_val = lv[WIDTH-1:0];
        en       = e;
        up       = u;
        mode     = md[1:0];
        #1;
        for (int k = 0; k < NDUT; k++) begin
            check($sformatf("sat[%0d]", k), dut_sat(k),
                  int'((md == 1) && (m_count[k] == (u ? MAXV[k] : 0))));
        end
        for (int k = 0; k < NDUT; k++) begin
            model_step(k, ld, lv, e, u, md, t);
            x.c[k] = m_count[k];
            x.t[k] = t;
            x.d[k] = m_done[k];
        end
        exp_q.push_back(x);
    endtask

    // Assert reset between edges and check outputs without any clock edge.
    task automatic async_reset();
        exp_t x;
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        for (int k = 0; k < NDUT; k++) begin
            check($sformatf("rst_count[%0d]", k), dut_count(k), 0);
            check($sformatf("rst_tc[%0d]", k),    dut_tc(k),    0);
            check($sformatf("rst_done[%0d]", k),  dut_done(k),  0);
            m_count[k] = 0;
            m_done[k]  = 1'b0;
        end
        rst  = 1'b1;
        load = 1'b0;
        en   = 1'b0;
        // The next rising edge is a hold from the reset value.
        for (int k = 0; k < NDUT; k++) begin
            x.c[k] = 0;
            x.t[k] = 1'b0;
            x.d[k] = 1'b0;
        end
        exp_q.push_back(x);
    endtask

    // Monitor: compare registered outputs shortly after each rising edge.
    always @(posedge clk) begin
        exp_t x;
        #1;
        if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            for (int k = 0; k < NDUT; k++) begin
                check($sformatf("count[%0d]", k), dut_count(k), x.c[k]);
                check($sformatf("tc[%0d]", k),    dut_tc(k),    int'(x.t[k]));
                check($sformatf("done[%0d]", k),  dut_done(k),  int'(x.d[k]));
            end
        end
    end

    initial begin
        for (int k = 0; k < NDUT; k++) begin
            m_count[k] = 0;
            m_done[k]  = 1'b0;
        end

        // Reset state while held in reset across edges.
        repeat (2) @(negedge clk);
        for (int k = 0; k < NDUT; k++) begin
            check($sformatf("init_count[%0d]", k), dut_count(k), 0);
            check($sformatf("init_tc[%0d]", k),    dut_tc(k),    0);
            check($sformatf("init_done[%0d]", k),  dut_done(k),  0);
            check($sformatf("init_sat[%0d]", k),   dut_sat(k),   0);
        end
        rst = 1'b1;

        // Asynchronous reset mid-count at 9.
        cycle(1, 9, 0, 0, 0);
        cycle(0, 0, 1, 1, 0);
        async_reset();

        // WRAP down from 0: 15,14,...,0,15 (and 9..0,9 on the smaller one).
        cycle(1, 0, 0, 0, 0);
        repeat (18) cycle(0, 0, 1, 0, 0);

        // WRAP up from 0, past both bounds; reserved mode too.
        cycle(1, 0, 0, 1, 0);
        repeat (12) cycle(0, 0, 1, 1, 0);
        repeat (12) cycle(0, 0, 1, 1, 3);

        // SAT up from 8, hold at bound, then reverse off it.
        cycle(1, 8, 0, 1, 1);
        repeat (9) cycle(0, 0, 1, 1, 1);
        cycle(0, 0, 1, 0, 1);
        cycle(0, 0, 1, 0, 1);

        // ONESHOT down from 3: 2,1,0 then halt with a single tc, then reload.
        cycle(1, 3, 0, 0, 2);
        repeat (6) cycle(0, 0, 1, 0, 2);
        cycle(1, 5, 1, 0, 2);
        cycle(0, 0, 1, 1, 2);

        // Load wins over enable; 12 clamps to 9 on the smaller counter.
        cycle(1, 12, 1, 1, 0);
        cycle(0, 0, 0, 1, 0);

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 15) == 0), $urandom_range(0, 15),
                  ($urandom_range(0, 7) != 0), $urandom_range(0, 1),
                  $urandom_range(0, 3));
            if ($urandom_range(0, 99) == 0) async_reset();
        end

        // Drain: every queued expectation must be consumed within a few edges.
        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
